imm_decode_stage: RTL and testbench
===================================

# imm_decode_stage

Registered, parametrised immediate-decode pipeline stage for the RV core's decode path. It accepts `{instruction, pc}` beats over a valid/ready handshake, extracts and sign-extends the immediate to XLEN, and classifies its format. It also computes the PC-relative target for branch, JAL and AUIPC, and flags unsupported opcodes. It sits between fetch and the register-read/execute stage and provides full throughput under backpressure through a 2-entry skid buffer.

## Interface

**Parameters**
- `XLEN`, default 64: datapath width; legal values are 32 and 64 only.

**Ports**
- `i_clk`, input, 1: clock. One clock; all state is on the rising edge.
- `i_rst`, input, 1: reset. Asynchronous, active-high.
- `i_flush`, input, 1: synchronous discard of all buffered beats.
- `i_valid`, input, 1: upstream beat valid.
- `o_ready`, output, 1: stage can accept a beat.
- `i_instr`, input, 32: instruction word.
- `i_pc`, input, XLEN: PC of the instruction.
- `o_valid`, output, 1: output beat valid.
- `i_ready`, input, 1: downstream accepts the beat.
- `o_instr`, output, 32: instruction, passed through.
- `o_pc`, output, XLEN: PC, passed through.
- `o_imm`, output, XLEN: extended immediate.
- `o_imm_type`, output, 3: `imm_type_t` format code.
- `o_target`, output, XLEN: `pc + imm`.
- `o_target_vld`, output, 1: set for BRANCH, JAL and AUIPC.
- `o_illegal`, output, 1: opcode is not recognised.

## Operation

**Opcode to format mapping**
- LOAD, OP-IMM, OP-IMM-32, JALR → I.
- STORE → S.
- BRANCH → B.
- LUI, AUIPC → U.
- JAL → J.
- OP, OP-32 → I, with `o_imm` forced to 0.
- SYSTEM → see Configuration.
- Any other opcode → I, `o_imm`=0, `o_illegal`=1.

**Immediate extraction**
- I: `instr[31:20]`, sign-extended.
- S: `{instr[31:25], instr[11:7]}`, sign-extended.
- B: `{instr[31], instr[7], instr[30:25], instr[11:8], 0}`, sign-extended.
- J: `{instr[31], instr[19:12], instr[20], instr[30:21], 0}`, sign-extended.
- U: `{instr[31:12], 12'b0}`. Sign-extended from bit 31 when XLEN=64; no extension when XLEN=32.

**Target computation**
- `o_target` = `pc + imm`, modulo 2^XLEN; it wraps silently and has no carry-out.
- `o_target` is computed for every beat. It is meaningful only when `o_target_vld`=1.
- JALR's target depends on rs1 and is not computed here.

**Skid buffer**
- Entries: an output register (OUT) and a skid register (SKID).
- `o_ready` = !SKID.valid. This is registered and has no combinational path from `i_ready`.

**State machine: EMPTY / ONE / TWO**
- EMPTY
  - Accept → ONE.
- ONE
  - Accept and drain → ONE (OUT reloaded).
  - Accept without drain → TWO (beat goes to SKID).
  - Drain without accept → EMPTY.
- TWO
  - Drain → ONE (SKID moves into OUT).
  - No accept is possible in TWO.
- An accept is `i_valid & o_ready`; a drain is `o_valid & i_ready`.

**Ordering and flush**
- Beats leave in acceptance order.
- The decode is computed at accept time, so both entries hold fully decoded beats.
- `i_flush`=1 → next state EMPTY. Any beat offered in the same cycle is dropped.
- Flush takes priority over both accept and drain.

## Timing

- Latency: a beat accepted at edge N is presented on the outputs after edge N. With `i_ready`=1, it drains at edge N+1.
- Throughput: one beat per cycle while `i_ready`=1.
- `o_valid` = state != EMPTY.
- The outputs stay stable while `o_valid & !i_ready`.
- Reset values:
  - state = EMPTY.
  - `o_valid` = 0, `o_ready` = 1.
  - `o_instr`, `o_pc`, `o_imm`, `o_target`, `o_imm_type`, `o_target_vld`, `o_illegal` = 0.
- Reset asserted mid-transfer: all entries are lost immediately and asynchronously.
- Deassertion of reset is synchronised by the integrator.

## Configuration

- Macro: `IMM_DECODE_ZICSR_EN`.
- Defined:
  - SYSTEM with `funct3[2]`=1 → Z format; `o_imm` = zero-extended `instr[19:15]` (zimm).
  - Other SYSTEM instructions → I format.
- Undefined:
  - All SYSTEM instructions → I format (CSR field sign-extended).
  - `o_illegal` is 0 for SYSTEM in both cases.

## Structure

- Additions to `rv_pkg`:
  - `imm_type_t`: I, S, B, U, J, Z.
  - `OPCODE_SYSTEM`, `OPCODE_OP`, `OPCODE_OP_32`, `OPCODE_IMM_32`.
- Sub-module `imm_extract`: purely combinational, parametrised by XLEN. It produces the immediate, format, target-valid and illegal flags.
- The stage instantiates `imm_extract` once, at the input. It adds the PC adder and the skid buffer.

## Test plan

1. **ADDI sign extension.** XLEN=64, `0xFFF00093` (addi x1,x0,-1) → `o_imm`=0xFFFF_FFFF_FFFF_FFFF, type I, `o_target_vld`=0.
2. **Branch target.** `0xFE000EE3` (beq −4) with pc=0x1000 → `o_imm`=−4, `o_target`=0xFFC, type B, `o_target_vld`=1.
3. **LUI and JAL wrap.**
   - LUI `0x800000B7` → `o_imm`=0xFFFF_FFFF_8000_0000 at XLEN=64; 0x8000_0000 at XLEN=32.
   - XLEN=32, JAL `0x0080006F` with pc=0xFFFF_FFFC → `o_target`=0x0000_0004.
4. **CSR immediate.** `0x300FD073` (csrrwi) → `o_imm`=31, type Z with `IMM_DECODE_ZICSR_EN` defined; `o_imm`=0x300, type I without it. Unknown opcode 0x7F → `o_illegal`=1.
5. **Backpressure.**
   - Send beats A, B, C on back-to-back cycles with `i_ready`=0 → after B is accepted, `o_ready` drops to 0 and C is held upstream.
   - Raise `i_ready` → the outputs present A, then B, then C, with no loss or duplication.
6. **Flush and reset.**
   - In TWO, pulse `i_flush` with `i_valid`=1 → next cycle `o_valid`=0, `o_ready`=1, and the offered beat is dropped.
   - Assert `i_rst` mid-stream → outputs go to zero without a clock edge.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV decode definitions: immediate format codes and major opcodes.
package rv_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4,
    IMM_Z = 3'd5
  } imm_type_t;

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_OP_32  = 7'b0111011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction, format classification and illegal-opcode detection.
// Optional macro IMM_DECODE_ZICSR_EN: SYSTEM with funct3[2]=1 yields the zero-extended zimm.
module imm_extract
  import rv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      imm_type_o,
  output logic            target_vld_o,
  output logic            illegal_o
);

  logic [6:0]  opcode;
  logic [31:0] imm32;
  imm_type_t   imm_type;

  assign opcode = instr_i[6:0];

  always_comb begin
    imm_type     = IMM_I;
    imm32        = {{20{instr_i[31]}}, instr_i[31:20]};
    target_vld_o = 1'b0;
    illegal_o    = 1'b0;
    case (opcode)
      OPCODE_LOAD, OPCODE_OP_IMM, OPCODE_IMM_32, OPCODE_JALR: begin
      end
      OPCODE_STORE: begin
        imm_type = IMM_S;
        imm32    = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      end
      OPCODE_BRANCH: begin
        imm_type     = IMM_B;
        imm32        = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
        target_vld_o = 1'b1;
      end
      OPCODE_LUI: begin
        imm_type = IMM_U;
        imm32    = {instr_i[31:12], 12'b0};
      end
      OPCODE_AUIPC: begin
        imm_type     = IMM_U;
        imm32        = {instr_i[31:12], 12'b0};
        target_vld_o = 1'b1;
      end
      OPCODE_JAL: begin
        imm_type     = IMM_J;
        imm32        = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
        target_vld_o = 1'b1;
      end
      OPCODE_OP, OPCODE_OP_32: begin
        imm32 = 32'd0;
      end
      OPCODE_SYSTEM: begin
`ifdef IMM_DECODE_ZICSR_EN
        if (instr_i[14]) begin
          imm_type = IMM_Z;
          imm32    = {27'd0, instr_i[19:15]};
        end
`endif
      end
      default: begin
        imm32     = 32'd0;
        illegal_o = 1'b1;
      end
    endcase
  end

  assign imm_type_o = imm_type;

  // All formats are built as 32-bit sign-extended values, then widened to XLEN.
  generate
    if (XLEN == 64) begin : g_xlen64
      assign imm_o = {{(XLEN-32){imm32[31]}}, imm32};
    end else begin : g_xlen32
      assign imm_o = imm32;
    end
  endgenerate

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage: decode at accept time, PC-relative target, 2-entry skid buffer.
// Optional macro IMM_DECODE_ZICSR_EN is handled inside imm_extract.
module imm_decode_stage
  import rv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_imm,
  output logic [2:0]      o_imm_type,
  output logic [XLEN-1:0] o_target,
  output logic            o_target_vld,
  output logic            o_illegal
);

  localparam int BEAT_W = 32 + 3*XLEN + 3 + 1 + 1;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

  state_t            state_q, state_d;
  logic [BEAT_W-1:0] out_q, out_d;
  logic [BEAT_W-1:0] skid_q, skid_d;
  logic [BEAT_W-1:0] in_beat;

  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_type;
  logic            dec_tvld;
  logic            dec_ill;
  logic            accept;
  logic            drain;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr_i      (i_instr),
    .imm_o        (dec_imm),
    .imm_type_o   (dec_type),
    .target_vld_o (dec_tvld),
    .illegal_o    (dec_ill)
  );

  assign in_beat = {i_instr, i_pc, dec_imm, i_pc + dec_imm, dec_type, dec_tvld, dec_ill};

  // Ready depends only on registered state, so there is no path from i_ready.
  assign o_ready = (state_q != ST_TWO);
  assign o_valid = (state_q != ST_EMPTY);
  assign accept  = i_valid & o_ready;
  assign drain   = o_valid & i_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (i_flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            out_d   = in_beat;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            out_d = in_beat;
          end else if (accept) begin
            skid_d  = in_beat;
            state_d = ST_TWO;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (drain) begin
            out_d   = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  assign {o_instr, o_pc, o_imm, o_target, o_imm_type, o_target_vld, o_illegal} = out_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed self-checking bench for imm_decode_stage at XLEN=64 and XLEN=32 side by side.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        valid;
  logic        ready;
  logic [31:0] instr;
  logic [63:0] pc;

  logic        o_ready, o_valid, o_tvld, o_ill;
  logic [31:0] o_instr;
  logic [63:0] o_pc, o_imm, o_target;
  logic [2:0]  o_type;

  logic        r32, v32, tvld32, ill32;
  logic [31:0] instr32, pc32, imm32, tgt32;
  logic [2:0]  type32;

  int checks = 0;
  int errors = 0;

`ifdef IMM_DECODE_ZICSR_EN
  localparam logic [63:0] CSR_IMM  = 64'd31;
  localparam logic [2:0]  CSR_TYPE = 3'd5;
`else
  localparam logic [63:0] CSR_IMM  = 64'h300;
  localparam logic [2:0]  CSR_TYPE = 3'd0;
`endif

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(64)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(o_ready),
    .i_instr(instr), .i_pc(pc), .o_valid(o_valid), .i_ready(ready),
    .o_instr(o_instr), .o_pc(o_pc), .o_imm(o_imm), .o_imm_type(o_type),
    .o_target(o_target), .o_target_vld(o_tvld), .o_illegal(o_ill)
  );

  imm_decode_stage #(.XLEN(32)) dut32 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(r32),
    .i_instr(instr), .i_pc(pc[31:0]), .o_valid(v32), .i_ready(ready),
    .o_instr(instr32), .o_pc(pc32), .o_imm(imm32), .o_imm_type(type32),
    .o_target(tgt32), .o_target_vld(tvld32), .o_illegal(ill32)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [63:0] tgt;
    logic [2:0]  typ;
    logic        tvld;
    logic        ill;
    logic [31:0] imm32;
    logic [31:0] tgt32;
  } vec_t;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_handshake: got valid=%b ready=%b, expected valid=0 ready=1", o_valid, o_ready);
    end
    checks++;
    if ({o_instr, o_pc, o_imm, o_target, o_type, o_tvld, o_ill} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got instr=%h imm=%h target=%h, expected all zero", o_instr, o_imm, o_target);
    end
  endtask

  task automatic test_decode;
    vec_t v [10];
    v[0] = '{32'hFFF00093, 64'h0,        64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    v[1] = '{32'hFE000EE3, 64'h1000,     64'hFFFF_FFFF_FFFF_FFFC, 64'hFFC,                 3'd2, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'hFFC};
    v[2] = '{32'h800000B7, 64'h0,        64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000, 3'd3, 1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000};
    v[3] = '{32'h0080006F, 64'hFFFF_FFFC, 64'h8,                  64'h1_0000_0004,         3'd4, 1'b1, 1'b0, 32'h8,         32'h4};
    v[4] = '{32'h300FD073, 64'h0,        CSR_IMM,                 CSR_IMM,                 CSR_TYPE, 1'b0, 1'b0, CSR_IMM[31:0], CSR_IMM[31:0]};
    v[5] = '{32'h0000007F, 64'h40,       64'h0,                   64'h40,                  3'd0, 1'b0, 1'b1, 32'h0,         32'h40};
    v[6] = '{32'hFE20AC23, 64'h100,      64'hFFFF_FFFF_FFFF_FFF8, 64'hF8,                  3'd1, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'hF8};
    v[7] = '{32'h003100B3, 64'h10,       64'h0,                   64'h10,                  3'd0, 1'b0, 1'b0, 32'h0,         32'h10};
    v[8] = '{32'h00001097, 64'h2000,     64'h1000,                64'h3000,                3'd3, 1'b1, 1'b0, 32'h1000,      32'h3000};
    v[9] = '{32'h30009073, 64'h0,        64'h300,                 64'h300,                 3'd0, 1'b0, 1'b0, 32'h300,       32'h300};
    ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      valid = 1'b1;
      instr = v[i].instr;
      pc    = v[i].pc;
      tick();
      valid = 1'b0;
      checks++;
      if (o_valid !== 1'b1 || o_instr !== v[i].instr || o_pc !== v[i].pc) begin
        errors++;
        $display("FAIL decode%0d_pass: got valid=%b instr=%h pc=%h, expected 1 %h %h", i, o_valid, o_instr, o_pc, v[i].instr, v[i].pc);
      end
      checks++;
      if (o_imm !== v[i].imm || o_target !== v[i].tgt) begin
        errors++;
        $display("FAIL decode%0d_imm64: got imm=%h target=%h, expected %h %h", i, o_imm, o_target, v[i].imm, v[i].tgt);
      end
      checks++;
      if (o_type !== v[i].typ || o_tvld !== v[i].tvld || o_ill !== v[i].ill) begin
        errors++;
        $display("FAIL decode%0d_flags: got type=%0d tvld=%b ill=%b, expected %0d %b %b", i, o_type, o_tvld, o_ill, v[i].typ, v[i].tvld, v[i].ill);
      end
      checks++;
      if (imm32 !== v[i].imm32 || tgt32 !== v[i].tgt32 || type32 !== v[i].typ || ill32 !== v[i].ill) begin
        errors++;
        $display("FAIL decode%0d_xlen32: got imm=%h target=%h type=%0d ill=%b, expected %h %h %0d %b", i, imm32, tgt32, type32, ill32, v[i].imm32, v[i].tgt32, v[i].typ, v[i].ill);
      end
    end
    tick();
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL decode_drain: got valid=%b, expected 0", o_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_instr;
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1;
      instr = ((32'd10 + i) << 20) | 32'h93;
      pc    = 64'h400 + 4 * i;
      exp_instr = instr;
      tick();
      checks++;
      if (o_valid !== 1'b1 || o_ready !== 1'b1 || o_instr !== exp_instr || o_imm !== 64'(10 + i)) begin
        errors++;
        $display("FAIL b2b%0d: got valid=%b ready=%b instr=%h imm=%h, expected 1 1 %h %h", i, o_valid, o_ready, o_instr, o_imm, exp_instr, 64'(10 + i));
      end
    end
    valid = 1'b0;
    tick();
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_empty: got valid=%b, expected 0", o_valid);
    end
  endtask

  task automatic test_backpressure;
    ready = 1'b0;
    valid = 1'b1;
    pc    = 64'h0;
    instr = 32'h00100093;
    tick();
    checks++;
    if (o_valid !== 1'b1 || o_ready !== 1'b1 || o_instr !== 32'h00100093) begin
      errors++;
      $display("FAIL bp_a_accept: got valid=%b ready=%b instr=%h, expected 1 1 00100093", o_valid, o_ready, o_instr);
    end
    instr = 32'h00200093;
    tick();
    checks++;
    if (o_ready !== 1'b0 || o_instr !== 32'h00100093) begin
      errors++;
      $display("FAIL bp_b_skid: got ready=%b instr=%h, expected 0 00100093", o_ready, o_instr);
    end
    instr = 32'h00300093;
    tick();
    checks++;
    if (o_ready !== 1'b0 || o_instr !== 32'h00100093 || o_imm !== 64'd1) begin
      errors++;
      $display("FAIL bp_hold: got ready=%b instr=%h imm=%h, expected 0 00100093 1", o_ready, o_instr, o_imm);
    end
    ready = 1'b1;
    tick();
    checks++;
    if (o_valid !== 1'b1 || o_ready !== 1'b1 || o_instr !== 32'h00200093 || o_imm !== 64'd2) begin
      errors++;
      $display("FAIL bp_present_b: got valid=%b ready=%b instr=%h imm=%h, expected 1 1 00200093 2", o_valid, o_ready, o_instr, o_imm);
    end
    tick();
    valid = 1'b0;
    checks++;
    if (o_valid !== 1'b1 || o_instr !== 32'h00300093 || o_imm !== 64'd3) begin
      errors++;
      $display("FAIL bp_present_c: got valid=%b instr=%h imm=%h, expected 1 00300093 3", o_valid, o_instr, o_imm);
    end
    tick();
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty: got valid=%b, expected 0", o_valid);
    end
  endtask

  task automatic test_flush;
    ready = 1'b0;
    valid = 1'b1;
    instr = 32'h00500093;
    tick();
    instr = 32'h00600093;
    tick();
    instr = 32'h00700093;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    valid = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_two: got valid=%b ready=%b, expected 0 1", o_valid, o_ready);
    end
    valid = 1'b1;
    instr = 32'h00800093;
    tick();
    instr = 32'h00900093;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    valid = 1'b0;
    ready = 1'b1;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_one: got valid=%b ready=%b, expected 0 1", o_valid, o_ready);
    end
    tick();
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop: got valid=%b instr=%h, expected valid=0", o_valid, o_instr);
    end
  endtask

  task automatic test_async_reset;
    ready = 1'b0;
    valid = 1'b1;
    instr = 32'h00A00093;
    pc    = 64'h80;
    tick();
    valid = 1'b0;
    checks++;
    if (o_valid !== 1'b1 || o_instr !== 32'h00A00093) begin
      errors++;
      $display("FAIL areset_pre: got valid=%b instr=%h, expected 1 00A00093", o_valid, o_instr);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_instr !== 32'd0 || o_imm !== 64'd0 || o_target !== 64'd0 || o_pc !== 64'd0) begin
      errors++;
      $display("FAIL areset_outputs: got valid=%b ready=%b instr=%h imm=%h target=%h, expected 0 1 0 0 0", o_valid, o_ready, o_instr, o_imm, o_target);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    valid = 1'b0;
    ready = 1'b0;
    instr = 32'd0;
    pc    = 64'd0;
    #3;
    test_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    test_decode();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
